axi_ram_slave: RTL and testbench
================================

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 Param ADDR_W, default 10: word-address bits; memory holds 2**ADDR_W 32-bit words.
REQ-002 Param RD_DELAY, default 2: idle cycles between AR capture and rvalid, range 0..15.
REQ-003 Param WR_DELAY, default 2: idle cycles between AW+W completion and bvalid, range 0..15.
REQ-004 aclk  in  1  sole clock, rising edge.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 arid  in  4  read ID.
REQ-007 araddr  in  32  read byte address.
REQ-008 arvalid  in  1  read address valid.
REQ-009 arready  out  1  read address accept.
REQ-010 rid  out  4  returned read ID.
REQ-011 rdata  out  32  read data.
REQ-012 rresp  out  2  read response.
REQ-013 rlast  out  1  last read beat.
REQ-014 rvalid  out  1  read data valid.
REQ-015 rready  in  1  read data accept.
REQ-016 awid  in  4  write ID.
REQ-017 awaddr  in  32  write byte address.
REQ-018 awvalid  in  1  write address valid.
REQ-019 awready  out  1  write address accept.
REQ-020 wdata  in  32  write data.
REQ-021 wstrb  in  4  byte enables.
REQ-022 wvalid  in  1  write data valid.
REQ-023 wready  out  1  write data accept.
REQ-024 bid  out  4  returned write ID.
REQ-025 bresp  out  2  write response.
REQ-026 bvalid  out  1  write response valid.
REQ-027 bready  in  1  write response accept.

Function
REQ-028 Single-beat slave; len/size/burst ignored; rlast SHALL be 1 whenever rvalid=1; rresp and bresp SHALL be 2'b00.
REQ-029 Word index SHALL be addr[ADDR_W+1:2]; upper and lower-2 bits ignored (aliasing, no error response).
REQ-030 Read FSM RD_IDLE/RD_WAIT/RD_RESP; arready=1 only in RD_IDLE; arvalid&arready captures arid and index, loads counter with RD_DELAY, goes to RD_WAIT.
REQ-031 RD_WAIT decrements counter each cycle; at counter==0 it SHALL register rdata=mem[index] and enter RD_RESP the next cycle (RD_DELAY=0: rvalid in the cycle after capture).
REQ-032 RD_RESP: rvalid=1, rid/rdata held stable until rvalid&rready, then RD_IDLE; a new AR is accepted no earlier than the cycle after.
REQ-033 Write FSM WR_ADDR/WR_WAIT/WR_RESP; in WR_ADDR awready=1 until AW captured and wready=1 until W captured, independently and in either order or same cycle.
REQ-034 When both captured, counter loaded with WR_DELAY and WR_WAIT entered; at counter==0 memory SHALL be updated byte-wise per wstrb and WR_RESP entered next cycle.
REQ-035 WR_RESP: bvalid=1, bid held until bvalid&bready, then WR_ADDR with both capture flags cleared.
REQ-036 Read and write paths SHALL run concurrently; at most one outstanding read and one outstanding write.
REQ-037 Collision: write commit and read sample to same index in same cycle -> read SHALL return pre-write data.
REQ-038 wstrb=4'b0000 SHALL complete normally with memory unchanged.

Reset
REQ-039 aresetn low SHALL immediately force RD_IDLE, WR_ADDR, counters 0, capture flags 0, rvalid=0, bvalid=0, arready=1, awready=1, wready=1, rid/bid/rdata=0; memory contents not reset.
REQ-040 Reset mid-transaction SHALL abandon it with no memory update and no response after release.

Verification
REQ-041 RD_DELAY=2, preload mem[3]=0x11223344, AR addr 0x0C id 1 -> rvalid exactly 3 cycles after capture, rdata=0x11223344, rid=1, rlast=1.
REQ-042 W (0xAABBCCDD, wstrb 4'b0101) 2 cycles before AW addr 0x10 id 2 over 0x00000000 -> bid=2, then read 0x10 returns 0x00BB00DD.
REQ-043 rready held low 5 cycles in RD_RESP -> rvalid, rdata, rid stable; arready=0 throughout.
REQ-044 Write commit to index 5 (old 0x1, new 0x2) coincident with read sample of index 5 -> read returns 0x1; later read returns 0x2.
REQ-045 aresetn low during WR_WAIT -> bvalid never asserted, target word unchanged, awready=wready=1 after release.
REQ-046 Address 0x0000_1004 with ADDR_W=10 -> aliases index 1.

Source files
------------

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: single-beat AXI4 RAM slave with fixed read/write response delays
module axi_ram_slave #(
  parameter int ADDR_W   = 10,
  parameter int RD_DELAY = 2,
  parameter int WR_DELAY = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_ADDR, WR_WAIT, WR_RESP} wr_state_t;
  logic [31:0] mem [2**ADDR_W];
  rd_state_t rd_state;
  wr_state_t wr_state;
  logic [3:0] rd_cnt, wr_cnt;
  logic [ADDR_W-1:0] rd_idx, wr_idx;
  logic aw_done, w_done, aw_hs, w_hs, wr_commit;
  logic [31:0] wdata_q;
  logic [3:0] wstrb_q;
  logic unused_bits;
  assign aw_hs = awvalid & awready;
  assign w_hs = wvalid & wready;
  assign wr_commit = wr_state == WR_WAIT && wr_cnt == '0;
  assign rresp = 2'b00;
  assign bresp = 2'b00;
  assign rlast = rvalid;
  assign unused_bits = ^{araddr[31:ADDR_W+2], araddr[1:0], awaddr[31:ADDR_W+2], awaddr[1:0]};
  // read path: capture AR, count down the delay, sample the word, hold it until accepted
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      rd_state <= RD_IDLE;
      rd_cnt <= '0;
      rd_idx <= '0;
      arready <= 1'b1;
      rvalid <= 1'b0;
      rid <= '0;
      rdata <= '0;
    end else
      case (rd_state)
        RD_IDLE: if (arvalid && arready) begin
          rid <= arid;
          rd_idx <= araddr[ADDR_W+1:2];
          rd_cnt <= 4'(RD_DELAY);
          arready <= 1'b0;
          rd_state <= RD_WAIT;
        end
        RD_WAIT: if (rd_cnt == '0) begin
          rdata <= mem[rd_idx];
          rvalid <= 1'b1;
          rd_state <= RD_RESP;
        end else rd_cnt <= rd_cnt - 1'b1;
        RD_RESP: if (rready) begin
          rvalid <= 1'b0;
          arready <= 1'b1;
          rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
  // write path: collect AW and W in any order, count down the delay, then respond
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      wr_state <= WR_ADDR;
      wr_cnt <= '0;
      wr_idx <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      awready <= 1'b1;
      wready <= 1'b1;
      wdata_q <= '0;
      wstrb_q <= '0;
      bvalid <= 1'b0;
      bid <= '0;
    end else
      case (wr_state)
        WR_ADDR: begin
          if (aw_hs) begin
            bid <= awid;
            wr_idx <= awaddr[ADDR_W+1:2];
            aw_done <= 1'b1;
            awready <= 1'b0;
          end
          if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            w_done <= 1'b1;
            wready <= 1'b0;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            wr_cnt <= 4'(WR_DELAY);
            wr_state <= WR_WAIT;
          end
        end
        WR_WAIT: if (wr_cnt == '0) begin
          bvalid <= 1'b1;
          wr_state <= WR_RESP;
        end else wr_cnt <= wr_cnt - 1'b1;
        WR_RESP: if (bready) begin
          bvalid <= 1'b0;
          aw_done <= 1'b0;
          w_done <= 1'b0;
          awready <= 1'b1;
          wready <= 1'b1;
          wr_state <= WR_ADDR;
        end
        default: wr_state <= WR_ADDR;
      endcase
  // byte-enabled commit; a read sampling the same word this edge still sees the old value
  always_ff @(posedge aclk)
    if (wr_commit)
      for (int i = 0; i < 4; i++)
        if (wstrb_q[i]) mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed vector bench for axi_ram_slave
module tb_axi_ram_slave;
  localparam int RDL = 2;
  localparam int WRL = 2;
  logic aclk = 0, aresetn = 1;
  logic [3:0] arid = 0, awid = 0, wstrb = 0;
  logic [31:0] araddr = 0, awaddr = 0, wdata = 0;
  logic arvalid = 0, rready = 0, awvalid = 0, wvalid = 0, bready = 0;
  logic arready, rlast, rvalid, awready, wready, bvalid;
  logic [3:0] rid, bid;
  logic [31:0] rdata;
  logic [1:0] rresp, bresp;
  int checks = 0, fails = 0;

  always #5 aclk = ~aclk;

  axi_ram_slave #(.ADDR_W(10), .RD_DELAY(RDL), .WR_DELAY(WRL)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic        is_wr;
    logic [1:0]  mode;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          stall;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [3:0] id);
    int n = 0;
    awaddr = a; awid = id; awvalid = 1;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    chk("awready", awready, 1);
    @(negedge aclk);
    awvalid = 0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1;
    while (!wready && n < 50) begin @(negedge aclk); n++; end
    chk("wready", wready, 1);
    @(negedge aclk);
    wvalid = 0;
  endtask

  task automatic get_b(input logic [3:0] id);
    int n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    chk("bvalid", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, 0);
    bready = 1;
    @(negedge aclk);
    bready = 0;
    chk("bvalid_drop", bvalid, 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [3:0] id, input logic [1:0] mode);
    if (mode == 0) fork do_aw(a, id); do_w(d, s); join
    else if (mode == 1) begin do_w(d, s); @(negedge aclk); do_aw(a, id); end
    else begin do_aw(a, id); do_w(d, s); end
    get_b(id);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [31:0] exp,
                         input int stall);
    int n = 0;
    araddr = a; arid = id; arvalid = 1;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    chk("arready", arready, 1);
    @(negedge aclk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge aclk); n++; end
    chk("rd_latency", n, RDL + 1);
    chk("rdata", rdata, exp);
    chk("rid", rid, id);
    chk("rlast", rlast, 1);
    chk("rresp", rresp, 0);
    for (int k = 0; k < stall; k++) begin
      @(negedge aclk);
      chk("stall_rvalid", rvalid, 1);
      chk("stall_rdata", rdata, exp);
      chk("stall_rid", rid, id);
      chk("stall_arready", arready, 0);
    end
    rready = 1;
    @(negedge aclk);
    rready = 0;
    chk("rvalid_drop", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got_r, got_b, saw_b;
    logic [31:0] r_got;
    logic [3:0] b_got;
    vecs[0]  = '{1, 0, 4'd1,  32'h0000_000C, 32'h1122_3344, 4'hF, 0, 32'h0};
    vecs[1]  = '{0, 0, 4'd1,  32'h0000_000C, 32'h0,         4'h0, 0, 32'h1122_3344};
    vecs[2]  = '{1, 2, 4'd3,  32'h0000_0010, 32'h0000_0000, 4'hF, 0, 32'h0};
    vecs[3]  = '{1, 1, 4'd2,  32'h0000_0010, 32'hAABB_CCDD, 4'b0101, 0, 32'h0};
    vecs[4]  = '{0, 0, 4'd4,  32'h0000_0010, 32'h0,         4'h0, 5, 32'h00BB_00DD};
    vecs[5]  = '{1, 0, 4'd5,  32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0};
    vecs[6]  = '{0, 0, 4'd6,  32'h0000_0004, 32'h0,         4'h0, 0, 32'hDEAD_BEEF};
    vecs[7]  = '{1, 2, 4'd7,  32'h0000_0007, 32'h1234_5678, 4'b1010, 0, 32'h0};
    vecs[8]  = '{0, 0, 4'd8,  32'h0000_1004, 32'h0,         4'h0, 0, 32'h12AD_56EF};
    vecs[9]  = '{1, 0, 4'd9,  32'h0000_000C, 32'hFFFF_FFFF, 4'h0, 0, 32'h0};
    vecs[10] = '{0, 0, 4'd10, 32'h0000_000F, 32'h0,         4'h0, 0, 32'h1122_3344};
    vecs[11] = '{1, 1, 4'd15, 32'h0000_0FFC, 32'hA5A5_A5A5, 4'hF, 0, 32'h0};
    vecs[12] = '{0, 0, 4'd15, 32'hFFFF_FFFC, 32'h0,         4'h0, 0, 32'hA5A5_A5A5};

    #2 aresetn = 0;
    #1;
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rid", rid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rdata", rdata, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);

    for (int i = 0; i < 13; i++)
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].id, vecs[i].mode);
      else do_read(vecs[i].addr, vecs[i].id, vecs[i].exp, vecs[i].stall);

    // write commit and read sample hit index 5 on the same edge
    do_write(32'h14, 32'h1, 4'hF, 4'd3, 0);
    araddr = 32'h14; arid = 4'd9; arvalid = 1;
    awaddr = 32'h14; awid = 4'd4; awvalid = 1;
    wdata = 32'h2; wstrb = 4'hF; wvalid = 1;
    chk("col_ready", {arready, awready, wready}, 3'b111);
    @(negedge aclk);
    arvalid = 0; awvalid = 0; wvalid = 0;
    rready = 1; bready = 1;
    got_r = 0; got_b = 0; r_got = 0; b_got = 0;
    for (int k = 0; k < 20; k++) begin
      if (rvalid && !got_r) begin got_r = 1; r_got = rdata; end
      if (bvalid && !got_b) begin got_b = 1; b_got = bid; end
      @(negedge aclk);
    end
    rready = 0; bready = 0;
    chk("col_got_r", got_r, 1);
    chk("col_got_b", got_b, 1);
    chk("col_old_data", r_got, 32'h1);
    chk("col_bid", b_got, 4'd4);
    do_read(32'h14, 4'd2, 32'h2, 0);

    // reset while the write is waiting to commit
    do_write(32'h20, 32'hCAFE_F00D, 4'hF, 4'd1, 0);
    fork do_aw(32'h20, 4'hC); do_w(32'h1234_5678, 4'hF); join
    #1 aresetn = 0;
    #1;
    chk("mid_rst_awready", awready, 1);
    chk("mid_rst_wready", wready, 1);
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_bid", bid, 0);
    @(negedge aclk);
    aresetn = 1;
    saw_b = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      saw_b |= bvalid;
    end
    chk("no_b_after_rst", saw_b, 0);
    chk("post_rst_awready", awready, 1);
    chk("post_rst_wready", wready, 1);
    do_read(32'h20, 4'd5, 32'hCAFE_F00D, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
